// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 DVP frame source: FSM state encoding,
// default frame geometry and RGB565 field positions.
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } dvp_state_e;

    localparam int DEF_X_MAX = 640;
    localparam int DEF_Y_MAX = 480;

    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    // High byte carries R and the top of G, low byte carries the rest of G and B.
    function automatic logic [7:0] rgb565_byte(input logic [15:0] pix, input logic lo_sel);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        logic [7:0] res;
        r = pix[RGB_R_MSB:RGB_R_LSB];
        g = pix[RGB_G_MSB:RGB_G_LSB];
        b = pix[RGB_B_MSB:RGB_B_LSB];
        if (lo_sel) begin
            res = {g[2:0], b};
        end else begin
            res = {r, g[5:3]};
        end
        return res;
    endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// Line/frame timing for the DVP emulator: horizontal byte counter, per-state line
// counter and frame FSM, plus decoded strobes for the read/mux logic.
module dvp_timing_gen
    import ov7670_pkg::*;
#(
    parameter int X_MAX       = DEF_X_MAX,
    parameter int Y_MAX       = DEF_Y_MAX,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       enable_i,
    output dvp_state_e state_o,
    output logic       line_active_o,
    output logic       rd_slot_o,
    output logic       byte_lo_o,
    output logic       frame_end_o
);

    localparam int LINE_LEN = 2 * X_MAX + H_BLANK;
    localparam int HW       = $clog2(LINE_LEN);
    localparam int VW       = 16;

    dvp_state_e      state_q, state_d, nxt_s;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic            line_active_q, line_active_d;
    logic            rd_slot_q, rd_slot_d;
    logic            byte_lo_q, byte_lo_d;
    logic            frame_end_q, frame_end_d;
    logic            line_end_s, last_line_s, wrap_s;

    function automatic logic [VW-1:0] lines_of(input dvp_state_e s);
        logic [VW-1:0] n;
        case (s)
            ST_VSYNC:  n = VW'(VSYNC_LINES);
            ST_VBACK:  n = VW'(V_BACK);
            ST_ACTIVE: n = VW'(Y_MAX);
            ST_VFRONT: n = VW'(V_FRONT);
            default:   n = {VW{1'b0}};
        endcase
        return n;
    endfunction

    function automatic dvp_state_e succ(input dvp_state_e s);
        dvp_state_e n;
        case (s)
            ST_VSYNC:  n = ST_VBACK;
            ST_VBACK:  n = ST_ACTIVE;
            ST_ACTIVE: n = ST_VFRONT;
            default:   n = ST_VSYNC;
        endcase
        return n;
    endfunction

    // Next state, counters and look-ahead strobes; IDLE starts as if leaving VFRONT.
    always_comb begin
        line_end_s  = (h_q == HW'(LINE_LEN - 1));
        last_line_s = (v_q == (lines_of(state_q) - VW'(1)));
        if (state_q == ST_IDLE) begin
            nxt_s = ST_VFRONT;
        end else begin
            nxt_s = state_q;
        end
        wrap_s = 1'b0;
        // Step once, then keep stepping past any state that owns zero lines.
        for (int i = 0; i < 5; i++) begin
            if ((i == 0) || (lines_of(nxt_s) == {VW{1'b0}})) begin
                if (nxt_s == ST_VFRONT) begin
                    wrap_s = 1'b1;
                end else begin
                    wrap_s = wrap_s;
                end
                nxt_s = succ(nxt_s);
            end else begin
                nxt_s = nxt_s;
            end
        end
        if (wrap_s && !enable_i) begin
            nxt_s = ST_IDLE;
        end else begin
            nxt_s = nxt_s;
        end

        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        if (state_q == ST_IDLE) begin
            h_d = {HW{1'b0}};
            v_d = {VW{1'b0}};
            if (enable_i) begin
                state_d = nxt_s;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (line_end_s) begin
            h_d = {HW{1'b0}};
            if (last_line_s) begin
                v_d     = {VW{1'b0}};
                state_d = nxt_s;
            end else begin
                v_d = v_q + VW'(1);
            end
        end else begin
            h_d = h_q + HW'(1);
        end

        frame_end_d   = (state_q != ST_IDLE) && line_end_s && last_line_s && wrap_s;
        line_active_d = (state_d == ST_ACTIVE) && (h_d < HW'(2 * X_MAX));
        rd_slot_d     = line_active_d && !h_d[0];
        byte_lo_d     = line_active_d && h_d[0];
    end

    // Timing state register.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            h_q           <= {HW{1'b0}};
            v_q           <= {VW{1'b0}};
            line_active_q <= 1'b0;
            rd_slot_q     <= 1'b0;
            byte_lo_q     <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            line_active_q <= line_active_d;
            rd_slot_q     <= rd_slot_d;
            byte_lo_q     <= byte_lo_d;
            frame_end_q   <= frame_end_d;
        end
    end

    assign state_o       = state_q;
    assign line_active_o = line_active_q;
    assign rd_slot_o     = rd_slot_q;
    assign byte_lo_o     = byte_lo_q;
    assign frame_end_o   = frame_end_q;

endmodule

// File: rtl/ov7670_frame_source.sv
// OV7670 DVP sensor emulator: replays an RGB565 frame from a synchronous-read pixel
// memory as vsync/href/8-bit data, high byte first, with a 2-stage output pipeline.
module ov7670_frame_source
    import ov7670_pkg::*;
#(
    parameter int X_MAX       = DEF_X_MAX,
    parameter int Y_MAX       = DEF_Y_MAX,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int ADDR_W      = 19
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              vsync,
    output logic              href,
    output logic [7:0]        d,
    output logic              frame_done
);

    dvp_state_e        state_s;
    logic              line_active_s, rd_slot_s, byte_lo_s, frame_end_s;
    logic [ADDR_W-1:0] pix_idx_q, pix_idx_d;
    logic [15:0]       pix_q, pix_d;
    logic              s1_vs_q, s1_href_q, s1_lo_q, s1_fd_q;
    logic              vsync_q, href_q, fd_q;
    logic [7:0]        d_q, d_d;

    dvp_timing_gen #(
        .X_MAX       (X_MAX),
        .Y_MAX       (Y_MAX),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) u_timing (
        .pclk          (pclk),
        .rst_n         (rst_n),
        .enable_i      (enable),
        .state_o       (state_s),
        .line_active_o (line_active_s),
        .rd_slot_o     (rd_slot_s),
        .byte_lo_o     (byte_lo_s),
        .frame_end_o   (frame_end_s)
    );

    // Pixel index, pixel latch and byte mux; the high byte comes straight from the
    // word being latched this cycle so it lines up with the 2-cycle output lag.
    always_comb begin
        pix_idx_d = pix_idx_q;
        if ((state_s == ST_IDLE) || frame_end_s) begin
            pix_idx_d = {ADDR_W{1'b0}};
        end else if (rd_slot_s) begin
            pix_idx_d = pix_idx_q + ADDR_W'(1);
        end else begin
            pix_idx_d = pix_idx_q;
        end

        if (byte_lo_s) begin
            pix_d = rd_data;
        end else begin
            pix_d = pix_q;
        end

        if (s1_href_q) begin
            d_d = rgb565_byte(pix_d, s1_lo_q);
        end else begin
            d_d = 8'h00;
        end
    end

    // Read address, pixel register and output pipeline stages.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_idx_q <= {ADDR_W{1'b0}};
            pix_q     <= 16'h0000;
            s1_vs_q   <= 1'b0;
            s1_href_q <= 1'b0;
            s1_lo_q   <= 1'b0;
            s1_fd_q   <= 1'b0;
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
            d_q       <= 8'h00;
            fd_q      <= 1'b0;
        end else begin
            pix_idx_q <= pix_idx_d;
            pix_q     <= pix_d;
            s1_vs_q   <= (state_s == ST_VSYNC);
            s1_href_q <= line_active_s;
            s1_lo_q   <= byte_lo_s;
            s1_fd_q   <= frame_end_s;
            vsync_q   <= s1_vs_q;
            href_q    <= s1_href_q;
            d_q       <= d_d;
            fd_q      <= s1_fd_q;
        end
    end

    assign rd_en      = rd_slot_s;
    assign rd_addr    = pix_idx_q;
    assign vsync      = vsync_q;
    assign href       = href_q;
    assign d          = d_q;
    assign frame_done = fd_q;

endmodule

// File: doc/ov7670_frame_source.md
Name: ov7670_frame_source

Overview:
- Sensor-side emulator for the OV7670 DVP pixel bus.
- Reads a stored RGB565 frame from a synchronous-read pixel memory and replays it as vsync/href/8-bit data on pclk.
- Output format is high byte first, two bytes per pixel, so the existing OV7670 capture path can be exercised in simulation and on-board without a camera.
- Sits between a frame BRAM read port and the capture path's pclk/vsync/href/d inputs.

Parameters:
- X_MAX, 640: active pixels per line.
- Y_MAX, 480: active lines per frame.
- H_BLANK, 144: blank pclk cycles per line after the 2*X_MAX active bytes; must be ≥2.
- VSYNC_LINES, 3: line periods with vsync=1.
- V_BACK, 17: blank lines after vsync, before the first active line.
- V_FRONT, 10: blank lines after the last active line.
- ADDR_W, 19: pixel memory address width; must satisfy 2^ADDR_W ≥ X_MAX*Y_MAX.

Ports:
- pclk, input, 1: pixel/byte clock; all logic is on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: run frames; sampled only at frame boundaries.
- rd_en, output, 1: pixel memory read strobe.
- rd_addr, output, ADDR_W: pixel address, y*X_MAX+x.
- rd_data, input, 16: RGB565 word, valid exactly 1 cycle after rd_en.
- vsync, output, 1: frame sync, active high.
- href, output, 1: line valid, active high.
- d, output, 8: pixel byte.
- frame_done, output, 1: 1-cycle pulse at the end of each frame.

Behaviour:
- Reset values: rd_en=0, rd_addr=0, vsync=0, href=0, d=0, frame_done=0. All counters go to 0 and the FSM goes to IDLE. Reset takes effect immediately, including mid-frame; the next frame starts from VSYNC.
- Timing counters:
  - LINE_LEN = 2*X_MAX + H_BLANK.
  - h counts 0..LINE_LEN-1 and wraps.
  - v counts lines within the current FSM state.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
- FSM transitions:
  - IDLE → VSYNC when enable=1, with h=0 and v=0.
  - VSYNC → VBACK after VSYNC_LINES lines.
  - VBACK → ACTIVE after V_BACK lines.
  - ACTIVE → VFRONT after Y_MAX lines.
  - A state with a zero-line count is skipped.
  - At the last cycle of VFRONT (v=V_FRONT-1, h=LINE_LEN-1): pulse frame_done, then go to VSYNC if enable=1, else IDLE.
  - Deasserting enable mid-frame never truncates a frame.
- Memory reads:
  - In ACTIVE, at h=2p (p=0..X_MAX-1), assert rd_en for one cycle with rd_addr = pixel index.
  - The pixel index resets to 0 on entering VSYNC and increments after each read. There is no wrap within a frame; the last address is X_MAX*Y_MAX-1.
  - rd_data is latched into a pixel register at h=2p+1.
- Output pipeline:
  - vsync, href and d are registered and lag the internal h/state by exactly 2 cycles.
  - href=1 for exactly 2*X_MAX consecutive cycles per active line.
  - d = pix[15:8], then pix[7:0] on the next cycle.
  - d=0 whenever href=0.
  - vsync=1 for exactly VSYNC_LINES*LINE_LEN consecutive cycles.
  - vsync and href are never both 1.
- frame_done is registered with the same 2-cycle lag, so it coincides with the cycle after the final output blank cycle of VFRONT.
- Cycle counts:
  - One frame = (VSYNC_LINES + V_BACK + Y_MAX + V_FRONT) * LINE_LEN cycles.
  - Back-to-back frames have no gap cycles.

Decomposition:
- Package ov7670_pkg holds:
  - FSM state enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT).
  - Default X_MAX/Y_MAX.
  - RGB565 field positions (R[15:11], G[10:5], B[4:0]).
- One sub-module, dvp_timing_gen, produces h, v, state, line_active and frame_end.
- The top level adds the memory read logic, byte mux and 2-stage output pipeline.

Test Plan:
All scenarios use X_MAX=4, Y_MAX=3, H_BLANK=4, VSYNC_LINES=2, V_BACK=1, V_FRONT=1 (LINE_LEN=12, frame=84 cycles). The memory model returns 16'hA000+addr.
- Reset/idle: rst_n=0 then 1 with enable=0 for 50 cycles → vsync, href, d, rd_en and frame_done stay 0.
- Single frame: enable=1 for 1 cycle, then 0 →
  - vsync high for exactly 24 cycles;
  - 3 href bursts of 8 cycles each;
  - first bytes A0,00,A0,01; last byte of the frame 0B;
  - exactly 12 rd_en pulses with addresses 0..11;
  - frame_done pulses once, 84 cycles after the first vsync cycle;
  - then IDLE.
- Continuous run: enable held at 1 for 3 frames → frame_done spacing is 84 cycles, no gap between frames, and rd_addr restarts at 0 every frame.
- Mid-frame disable: drop enable during ACTIVE line 1 → the frame completes with all 12 pixels, then no further vsync.
- Async reset mid-line: rst_n=0 at the 3rd href byte → outputs go to 0 without waiting for a pclk edge. After release with enable=1, the first active byte is A0 then 00 (address 0).
- Loopback: drive the OV7670 capture path from this block → captured write words equal A000..A00B in order.
